// File: rtl/seg7_bcd_capture.sv
// seg7_bcd_capture: recovers BCD digits from a multiplexed 7-segment bus,
// flags illegal patterns and hands complete frames out over valid/ready.
// Optional build macro SEG7_CAP_SYNC_EN adds a two-flop input synchronizer.
module seg7_bcd_capture #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_overrun
);

    localparam int unsigned SW = DIGITS + 7;
    localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam int unsigned BW = 4 * DIGITS;

    logic [SW-1:0]     in_w;
    logic [SW-1:0]     sample_q;
    logic [CW-1:0]     cnt_q;
    logic [DIGITS-1:0] sel_c;
    logic              onehot_c;
    logic              capture_c;
    logic              frame_done_c;
    logic [4:0]        dec_c;
    logic [BW-1:0]     dig_q, dig_nxt_c;
    logic [DIGITS-1:0] err_q, err_nxt_c;
    logic [DIGITS-1:0] seen_q, seen_nxt_c;

`ifdef SEG7_CAP_SYNC_EN
    logic [SW-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for panel inputs asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {dig_sel, seg_in};
            sync2_q <= sync1_q;
        end
    end

    assign in_w = sync2_q;
`else
    assign in_w = {dig_sel, seg_in};
`endif

    // {err, bcd} for one segment pattern; blank maps to F, illegal to E
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h00:   decode = 5'h0F;
            default: decode = 5'h1E;
        endcase
    endfunction

    // Sample register and run-length counter (cnt = identical samples - 1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            cnt_q    <= '0;
        end else begin
            sample_q <= in_w;
            if (in_w != sample_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CW'(STABLE_CYCLES)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Capture decision, decode and next digit/error/seen state
    always_comb begin
        sel_c        = sample_q[SW-1:7];
        onehot_c     = (sel_c != '0) && ((sel_c & (sel_c - DIGITS'(1))) == '0);
        capture_c    = onehot_c && (cnt_q == CW'(STABLE_CYCLES - 1));
        dec_c        = decode(sample_q[6:0]);
        dig_nxt_c    = dig_q;
        err_nxt_c    = err_q;
        seen_nxt_c   = seen_q;
        if (capture_c) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (sel_c[i]) begin
                    dig_nxt_c[i*4 +: 4] = dec_c[3:0];
                    err_nxt_c[i]        = dec_c[4];
                end
            end
            seen_nxt_c = seen_q | sel_c;
        end
        frame_done_c = capture_c && (&seen_nxt_c);
    end

    // Digit registers, seen mask and output frame handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q         <= '0;
            err_q         <= '0;
            seen_q        <= '0;
            bcd_out       <= '0;
            digit_err     <= '0;
            out_valid     <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            dig_q  <= dig_nxt_c;
            err_q  <= err_nxt_c;
            seen_q <= seen_nxt_c;
            if (frame_done_c) begin
                seen_q <= '0;
                if (!out_valid || out_ready) begin
                    bcd_out   <= dig_nxt_c;
                    digit_err <= err_nxt_c;
                    out_valid <= 1'b1;
                end else begin
                    frame_overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Directed bench for seg7_bcd_capture (DIGITS=4, STABLE_CYCLES=3).
// Honours SEG7_CAP_SYNC_EN by adding two clocks of capture latency.
module tb_seg7_bcd_capture;

    localparam int unsigned DIGITS = 4;
`ifdef SEG7_CAP_SYNC_EN
    localparam int unsigned LAT = 5;
`else
    localparam int unsigned LAT = 3;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_err;
    logic                out_valid;
    logic                out_ready;
    logic                frame_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_bcd_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_in        (seg_in),
        .dig_sel       (dig_sel),
        .bcd_out       (bcd_out),
        .digit_err     (digit_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [3:0] d, input logic [6:0] s);
        dig_sel = d;
        seg_in  = s;
    endtask

    // Show four digits for 4 clocks each, then idle long enough to flush
    task automatic send4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        put(4'b0001, s0); tick(4);
        put(4'b0010, s1); tick(4);
        put(4'b0100, s2); tick(4);
        put(4'b1000, s3); tick(4);
        put(4'b0000, 7'h00); tick(LAT + 1);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        put(4'b0000, 7'h00);
        tick(3);
        check("rst_bcd",   32'(bcd_out), 32'h0);
        check("rst_err",   32'(digit_err), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ovr",   32'(frame_overrun), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Basic frame with exact completion latency
        put(4'b0001, 7'h3F); tick(4);
        put(4'b0010, 7'h06); tick(4);
        put(4'b0100, 7'h5B); tick(4);
        put(4'b1000, 7'h4F); tick(LAT);
        check("t1_valid_early", 32'(out_valid), 32'h0);
        tick(1);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_bcd",   32'(bcd_out), 32'h3210);
        check("t1_err",   32'(digit_err), 32'h0);
        put(4'b0000, 7'h00); tick(LAT + 1);
        check("t1_hold_bcd", 32'(bcd_out), 32'h3210);
        pop();
        check("t1_pop_valid", 32'(out_valid), 32'h0);
        check("t1_ovr", 32'(frame_overrun), 32'h0);

        // Glitching digit 0 must not be captured
        for (int i = 0; i < 6; i++) begin
            put(4'b0001, (i % 2 == 0) ? 7'h3F : 7'h06);
            tick(2);
        end
        put(4'b0010, 7'h6D); tick(4);
        put(4'b0100, 7'h7D); tick(4);
        put(4'b1000, 7'h07); tick(4);
        put(4'b0000, 7'h00); tick(LAT + 1);
        check("t2_no_frame", 32'(out_valid), 32'h0);
        put(4'b0001, 7'h3F); tick(4);
        put(4'b0000, 7'h00); tick(LAT + 1);
        check("t2_valid", 32'(out_valid), 32'h1);
        check("t2_bcd",   32'(bcd_out), 32'h7650);
        pop();

        // Illegal pattern on digit 2, blank on digit 3, then recovery
        send4(7'h7F, 7'h6F, 7'h7E, 7'h00);
        check("t3_valid", 32'(out_valid), 32'h1);
        check("t3_bcd",   32'(bcd_out), 32'hFE98);
        check("t3_err",   32'(digit_err), 32'h4);
        pop();
        send4(7'h3F, 7'h06, 7'h66, 7'h4F);
        check("t3b_bcd", 32'(bcd_out), 32'h3410);
        check("t3b_err", 32'(digit_err), 32'h0);
        pop();

        // Two frames with the consumer stalled
        send4(7'h06, 7'h06, 7'h06, 7'h06);
        check("t4_bcd_a", 32'(bcd_out), 32'h1111);
        check("t4_ovr_a", 32'(frame_overrun), 32'h0);
        send4(7'h5B, 7'h5B, 7'h5B, 7'h5B);
        check("t4_valid", 32'(out_valid), 32'h1);
        check("t4_bcd_b", 32'(bcd_out), 32'h1111);
        check("t4_ovr_b", 32'(frame_overrun), 32'h1);
        pop();
        check("t4_pop_valid", 32'(out_valid), 32'h0);
        check("t4_ovr_sticky", 32'(frame_overrun), 32'h1);

        // Multi-hot and all-zero select are ignored
        put(4'b0011, 7'h3F); tick(10);
        put(4'b0000, 7'h06); tick(10);
        put(4'b0010, 7'h5B); tick(4);
        put(4'b0100, 7'h66); tick(4);
        put(4'b1000, 7'h07); tick(4);
        put(4'b0000, 7'h00); tick(LAT + 1);
        check("t5_no_frame", 32'(out_valid), 32'h0);
        put(4'b0001, 7'h7D); tick(4);
        put(4'b0000, 7'h00); tick(LAT + 1);
        check("t5_valid", 32'(out_valid), 32'h1);
        check("t5_bcd",   32'(bcd_out), 32'h7426);
        pop();

        // Asynchronous reset mid-frame discards partial data
        put(4'b0001, 7'h3F); tick(4);
        put(4'b0010, 7'h06); tick(4);
        put(4'b0000, 7'h00); tick(LAT + 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_bcd", 32'(bcd_out), 32'h0);
        check("t6_rst_ovr", 32'(frame_overrun), 32'h0);
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        put(4'b0100, 7'h6D); tick(4);
        put(4'b1000, 7'h7F); tick(4);
        put(4'b0000, 7'h00); tick(LAT + 1);
        check("t6_partial", 32'(out_valid), 32'h0);
        put(4'b0001, 7'h06); tick(4);
        put(4'b0010, 7'h5B); tick(4);
        put(4'b0000, 7'h00); tick(LAT + 1);
        check("t6_valid", 32'(out_valid), 32'h1);
        check("t6_bcd",   32'(bcd_out), 32'h8521);
        check("t6_err",   32'(digit_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_bcd_capture.md
Name: seg7_bcd_capture

Overview:
- Inverse of the team's BCD-to-7-segment decoder.
- Monitors a multiplexed 7-segment display bus (segment lines plus one-hot digit select) and recovers the BCD digit shown on each position.
- Flags any segment pattern that is not a legal digit.
- Presents complete multi-digit frames to downstream logic over a valid/ready handshake; used for display self-check and for scraping legacy display panels.

Parameters:
- DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 3: consecutive identical samples required before a digit is captured (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- seg_in  in  7  segments, active-high; bit0=a … bit6=g.
- dig_sel  in  DIGITS  digit select, active-high, expected one-hot.
- bcd_out  out  4*DIGITS  frame digits; nibble i = digit i.
- digit_err  out  DIGITS  bit i set = digit i pattern illegal in this frame.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts frame.
- frame_overrun  out  1  sticky; a frame was dropped because the output was held.

Behaviour:
- One clock domain. rst_n is asynchronous, active-low. On reset, clear all state and outputs:
  - bcd_out=0, digit_err=0, out_valid=0, frame_overrun=0.
  - seen mask, stability counter and sample registers also cleared.
- Input stage: {dig_sel, seg_in} registered once per clk (sample).
- Stability counter:
  - Reset to 0 when the sample differs from the previous sample; otherwise increment, saturating.
  - A capture fires exactly once when the sample has been identical for STABLE_CYCLES consecutive clocks AND dig_sel is one-hot.
  - No further capture until the sample changes.
  - dig_sel all-zero or multi-hot: never captured and not an error.
- Latency: inputs constant from edge k through edge k+STABLE_CYCLES-1 → digit register updated at edge k+STABLE_CYCLES (no sync stage).
- Pattern decode (7'h = g..a):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - 00→4'hF (blank, no error).
  - Anything else → 4'hE with the per-digit error bit set.
  - A legal capture clears that digit's error bit.
- Seen mask: capture of digit i sets seen[i]. When a capture makes the mask all ones, the frame is complete (same edge as the digit register update):
  - If out_valid==0, or out_valid&&out_ready in that cycle: load bcd_out/digit_err from the digit registers, including the just-captured value; out_valid=1; clear mask.
  - Otherwise: keep bcd_out, digit_err and out_valid unchanged; set frame_overrun; clear mask.
- Handshake:
  - out_valid && out_ready with no simultaneous load → out_valid=0 next edge.
  - bcd_out and digit_err are stable while out_valid=1 and out_ready=0.
- Recapturing a digit already in the seen mask updates its register but does not complete the frame early.
- Reset mid-frame discards partial data; no frame is emitted for it.

Optional Feature:
- SEG7_CAP_SYNC_EN defined: two-flop synchronizer on seg_in and dig_sel ahead of the sample register, for asynchronous panel inputs. All capture latencies increase by exactly 2 clocks; function is otherwise identical.
- Not defined: no synchronizer; inputs are assumed synchronous to clk.

Test Plan:
- Reset release, DIGITS=4, STABLE_CYCLES=3. Drive dig_sel=0001/seg=3F, 0010/06, 0100/5B, 1000/4F, 4 clocks each → out_valid=1, bcd_out=16'h3210, digit_err=0 at the edge after the 3rd stable sample of digit 3.
- Glitch: seg changes every 2 clocks on digit 0 → no capture, seen mask unchanged, out_valid stays 0.
- Illegal pattern 7'h7E on digit 2 within a full frame → nibble 2 = 4'hE, digit_err=4'b0100. Next frame with 7'h66 on digit 2 → nibble 4, digit_err=0.
- Hold out_ready=0 across two complete frames → first frame stays on bcd_out, frame_overrun=1. Assert out_ready → out_valid falls next edge.
- dig_sel=0011 or 0000 held 10 clocks → no capture. Blank seg=00 on digit 3 → nibble 3 = 4'hF, no error.
- Assert rst_n low after two digits captured → all outputs 0 asynchronously. Complete frame after release needs all four digits. With SEG7_CAP_SYNC_EN, case 1 completes 2 clocks later.
